// File: rtl/uart_ring_buf_ctrl.sv
// UART store-and-forward controller: received bytes go into a circular buffer.
// A dump sends a snapshot of the stored bytes through the transmitter.
// A dump is started by a key press (manual mode) or by a fill threshold or
// receive-idle timeout (auto mode).
//
// state  | meaning
// -------+------------------------------------------------------------
// S_IDLE | no dump; evaluating triggers
// S_RD   | present rd_ptr to the RAM, pop one byte
// S_LAT  | RAM read latency cycle
// S_SEND | tx_data loaded, send_en high for this cycle only
// S_WAIT | wait for tx_done, then next byte or back to idle
module uart_ring_buf_ctrl #(
   parameter int DATA_W       = 8,
   parameter int ADDR_W       = 8,
   parameter int FLUSH_THRESH = 16,
   parameter int IDLE_TIMEOUT = 50000,
   parameter int CNT_W        = 16
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              mode,
   input  logic              key_flag,
   input  logic              key_state,
   input  logic              clr,
   input  logic [DATA_W-1:0] rx_data,
   input  logic              rx_done,
   input  logic              tx_done,
   output logic [DATA_W-1:0] tx_data,
   output logic              send_en,
   output logic              busy,
   output logic [ADDR_W:0]   count,
   output logic              overflow
);

   localparam int              DEPTH      = 2 ** ADDR_W;
   localparam logic [ADDR_W:0] DEPTH_C    = (ADDR_W + 1)'(DEPTH);
   localparam logic [ADDR_W:0] THRESH_C   = (ADDR_W + 1)'(FLUSH_THRESH);
   localparam logic [CNT_W-1:0] IDLE_MAX_C = CNT_W'(IDLE_TIMEOUT - 1);

   typedef enum logic [2:0] {S_IDLE, S_RD, S_LAT, S_SEND, S_WAIT} state_t;

   state_t              state_q, state_d;
   logic [ADDR_W-1:0]   wr_ptr_q, wr_ptr_d;
   logic [ADDR_W-1:0]   rd_ptr_q, rd_ptr_d;
   logic [ADDR_W:0]     count_q, count_d;
   logic [ADDR_W:0]     dump_n_q, dump_n_d;
   logic [CNT_W-1:0]    idle_cnt_q, idle_cnt_d;
   logic                overflow_q, overflow_d;
   logic                send_en_q, send_en_d;
   logic                busy_q, busy_d;
   logic [DATA_W-1:0]   tx_data_q, tx_data_d;

   logic [DATA_W-1:0]   mem [DEPTH];
   logic [DATA_W-1:0]   ram_q;
   logic                wr_en;
   logic                pop;
   logic                trigger;

   // Buffer RAM: write on accepted byte, registered read issued from S_RD.
   // A write never lands on the address being read: that would need
   // count==0 (no read) or count==DEPTH (write refused).
   always_ff @(posedge clk) begin
      if (wr_en) mem[wr_ptr_q] <= rx_data;
      if (state_q == S_RD) ram_q <= mem[rd_ptr_q];
   end

   // Next-state, pointer, occupancy and output computation.
   always_comb begin
      state_d    = state_q;
      wr_ptr_d   = wr_ptr_q;
      rd_ptr_d   = rd_ptr_q;
      count_d    = count_q;
      dump_n_d   = dump_n_q;
      idle_cnt_d = idle_cnt_q;
      overflow_d = overflow_q;
      busy_d     = busy_q;
      tx_data_d  = tx_data_q;
      send_en_d  = 1'b0;

      wr_en   = rx_done && (count_q < DEPTH_C) && !clr;
      pop     = (state_q == S_RD) && !clr;
      trigger = (state_q == S_IDLE) && (count_q != '0) &&
                ((!mode && key_flag && !key_state) ||
                 (mode && ((count_q >= THRESH_C) || (idle_cnt_q == IDLE_MAX_C))));

      unique case (state_q)
         S_IDLE: begin
            if (trigger) begin
               dump_n_d = count_q;
               busy_d   = 1'b1;
               state_d  = S_RD;
            end
         end
         S_RD: begin
            rd_ptr_d = rd_ptr_q + 1'b1;
            dump_n_d = dump_n_q - 1'b1;
            state_d  = S_LAT;
         end
         S_LAT:  state_d = S_SEND;
         S_SEND: state_d = S_WAIT;
         S_WAIT: begin
            if (tx_done) begin
               if (dump_n_q == '0) begin
                  busy_d     = 1'b0;
                  overflow_d = 1'b0;
                  state_d    = S_IDLE;
               end else begin
                  state_d = S_RD;
               end
            end
         end
         default: state_d = S_IDLE;
      endcase

      if (wr_en) wr_ptr_d = wr_ptr_q + 1'b1;
      count_d = count_q + (ADDR_W + 1)'(wr_en) - (ADDR_W + 1)'(pop);

      // A drop in the same cycle a dump completes is still reported.
      if (rx_done && (count_q == DEPTH_C)) overflow_d = 1'b1;

      if (rx_done || (count_q == '0)) begin
         idle_cnt_d = '0;
      end else if ((state_q == S_IDLE) && (idle_cnt_q != IDLE_MAX_C)) begin
         idle_cnt_d = idle_cnt_q + 1'b1;
      end

      if (clr) begin
         state_d    = S_IDLE;
         busy_d     = 1'b0;
         wr_ptr_d   = '0;
         rd_ptr_d   = '0;
         count_d    = '0;
         overflow_d = 1'b0;
         idle_cnt_d = '0;
      end

      if (state_d == S_SEND) begin
         send_en_d = 1'b1;
         tx_data_d = ram_q;
      end
   end

   // State and control registers.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state_q    <= S_IDLE;
         wr_ptr_q   <= '0;
         rd_ptr_q   <= '0;
         count_q    <= '0;
         dump_n_q   <= '0;
         idle_cnt_q <= '0;
         overflow_q <= 1'b0;
         send_en_q  <= 1'b0;
         busy_q     <= 1'b0;
         tx_data_q  <= '0;
      end else begin
         state_q    <= state_d;
         wr_ptr_q   <= wr_ptr_d;
         rd_ptr_q   <= rd_ptr_d;
         count_q    <= count_d;
         dump_n_q   <= dump_n_d;
         idle_cnt_q <= idle_cnt_d;
         overflow_q <= overflow_d;
         send_en_q  <= send_en_d;
         busy_q     <= busy_d;
         tx_data_q  <= tx_data_d;
      end
   end

   assign tx_data  = tx_data_q;
   assign send_en  = send_en_q;
   assign busy     = busy_q;
   assign count    = count_q;
   assign overflow = overflow_q;

endmodule

// File: tb/tb_uart_ring_buf_ctrl.sv
// Self-checking bench for uart_ring_buf_ctrl (depth 16, threshold 4, timeout 100).
// Reference model: a queue of stored bytes plus a sticky overflow flag.
module tb_uart_ring_buf_ctrl;

   localparam int DATA_W  = 8;
   localparam int ADDR_W  = 4;
   localparam int DEPTH   = 16;
   localparam int THRESH  = 4;
   localparam int TIMEOUT = 100;

   logic              clk = 1'b0;
   logic              rst = 1'b0;
   logic              mode = 1'b0;
   logic              key_flag = 1'b0;
   logic              key_state = 1'b1;
   logic              clr = 1'b0;
   logic [DATA_W-1:0] rx_data = '0;
   logic              rx_done = 1'b0;
   logic              tx_done = 1'b0;
   logic [DATA_W-1:0] tx_data;
   logic              send_en;
   logic              busy;
   logic [ADDR_W:0]   count;
   logic              overflow;

   int checks = 0;
   int errors = 0;

   logic [7:0] mq[$];
   logic       m_ovf = 1'b0;

   uart_ring_buf_ctrl #(
      .DATA_W(DATA_W), .ADDR_W(ADDR_W), .FLUSH_THRESH(THRESH),
      .IDLE_TIMEOUT(TIMEOUT), .CNT_W(16)
   ) dut (
      .clk(clk), .rst(rst), .mode(mode), .key_flag(key_flag), .key_state(key_state),
      .clr(clr), .rx_data(rx_data), .rx_done(rx_done), .tx_done(tx_done),
      .tx_data(tx_data), .send_en(send_en), .busy(busy), .count(count),
      .overflow(overflow)
   );

   always #5 clk = ~clk;

   initial begin
      #1_000_000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   task automatic cycle();
      @(posedge clk);
      #1;
   endtask

   task automatic pulse_rx(input logic [7:0] b);
      rx_data = b;
      rx_done = 1'b1;
      cycle();
      rx_done = 1'b0;
      if (mq.size() < DEPTH) mq.push_back(b);
      else m_ovf = 1'b1;
      checks++;
      if (count !== (ADDR_W + 1)'(mq.size())) begin
         errors++;
         $display("FAIL rx_count: count=%0d required %0d", count, mq.size());
      end
      checks++;
      if (overflow !== m_ovf) begin
         errors++;
         $display("FAIL rx_overflow: overflow=%b required %b", overflow, m_ovf);
      end
   endtask

   task automatic key_press(input logic st);
      key_flag  = 1'b1;
      key_state = st;
      cycle();
      key_flag  = 1'b0;
      key_state = 1'b1;
   endtask

   task automatic do_clr();
      clr = 1'b1;
      cycle();
      clr = 1'b0;
      mq.delete();
      m_ovf = 1'b0;
      checks++;
      if (count !== '0 || overflow !== 1'b0 || busy !== 1'b0) begin
         errors++;
         $display("FAIL clr_idle: count=%0d overflow=%b busy=%b required 0/0/0",
                  count, overflow, busy);
      end
   endtask

   // Serves a dump of n bytes; first_lat is the expected number of cycles
   // from the current cycle to the first send_en (negative: not checked).
   task automatic serve_dump(input int n, input int first_lat, input int inject);
      int waited;
      int d;
      int extra;
      int left;
      logic [7:0] exp;
      extra = 0;
      left  = inject;
      for (int i = 0; i < n; i++) begin
         waited = 0;
         while (send_en !== 1'b1 && waited < 300) begin
            cycle();
            waited++;
         end
         checks++;
         if (send_en !== 1'b1) begin
            errors++;
            $display("FAIL dump_start[%0d]: send_en=%b after %0d cycles, required 1",
                     i, send_en, waited);
            return;
         end
         if (i == 0 && first_lat >= 0) begin
            checks++;
            if (waited != first_lat) begin
               errors++;
               $display("FAIL dump_latency: first send_en after %0d cycles, required %0d",
                        waited, first_lat);
            end
         end
         exp = (mq.size() > 0) ? mq.pop_front() : 8'h00;
         checks++;
         if (tx_data !== exp) begin
            errors++;
            $display("FAIL dump_data[%0d]: tx_data=%02h required %02h", i, tx_data, exp);
         end
         checks++;
         if (busy !== 1'b1) begin
            errors++;
            $display("FAIL dump_busy[%0d]: busy=%b required 1", i, busy);
         end
         d = $urandom_range(1, 4);
         repeat (d) begin
            if (left > 0) begin
               rx_data = 8'($urandom);
               rx_done = 1'b1;
               if (mq.size() < DEPTH) mq.push_back(rx_data);
               else m_ovf = 1'b1;
               left--;
            end
            cycle();
            rx_done = 1'b0;
            if (send_en !== 1'b0 || tx_data !== exp) extra++;
         end
         tx_done = 1'b1;
         cycle();
         tx_done = 1'b0;
      end
      m_ovf = 1'b0;
      checks++;
      if (extra != 0) begin
         errors++;
         $display("FAIL dump_wait: %0d cycles with early send_en or changed tx_data, required 0",
                  extra);
      end
      checks++;
      if (busy !== 1'b0 || count !== (ADDR_W + 1)'(mq.size()) || overflow !== m_ovf) begin
         errors++;
         $display("FAIL dump_end: busy=%b count=%0d overflow=%b required 0/%0d/%b",
                  busy, count, overflow, mq.size(), m_ovf);
      end
      extra = 0;
      repeat (5) begin
         cycle();
         if (send_en !== 1'b0) extra++;
      end
      checks++;
      if (extra != 0) begin
         errors++;
         $display("FAIL dump_extra: %0d send_en pulses after dump, required 0", extra);
      end
   endtask

   task automatic test_reset();
      repeat (3) cycle();
      checks++;
      if (tx_data !== '0 || send_en !== 1'b0 || busy !== 1'b0 || count !== '0 ||
          overflow !== 1'b0) begin
         errors++;
         $display("FAIL reset: tx_data=%02h send_en=%b busy=%b count=%0d overflow=%b required all 0",
                  tx_data, send_en, busy, count, overflow);
      end
      rst = 1'b1;
      cycle();
   endtask

   task automatic test_basic();
      int seen;
      mode = 1'b0;
      pulse_rx(8'h11);
      pulse_rx(8'h22);
      pulse_rx(8'h33);
      key_press(1'b1);
      seen = 0;
      repeat (4) begin
         if (busy !== 1'b0 || send_en !== 1'b0) seen++;
         cycle();
      end
      checks++;
      if (seen != 0) begin
         errors++;
         $display("FAIL key_release: dump activity in %0d cycles, required 0", seen);
      end
      key_press(1'b0);
      serve_dump(3, 2, 0);
   endtask

   task automatic test_overflow();
      mode = 1'b0;
      for (int i = 0; i < 18; i++) pulse_rx(8'(i));
      key_press(1'b0);
      serve_dump(16, 2, 0);
   endtask

   task automatic test_wrap();
      mode = 1'b0;
      for (int i = 0; i < 10; i++) pulse_rx(8'($urandom));
      key_press(1'b0);
      serve_dump(10, 2, 0);
      for (int i = 0; i < 12; i++) pulse_rx(8'($urandom));
      key_press(1'b0);
      serve_dump(12, 2, 0);
   endtask

   task automatic test_threshold();
      mode = 1'b1;
      for (int i = 0; i < THRESH; i++) pulse_rx(8'($urandom));
      serve_dump(THRESH, 3, 2);
      do_clr();
   endtask

   task automatic test_timeout();
      mode = 1'b1;
      pulse_rx(8'hA5);
      key_press(1'b0);
      checks++;
      if (busy !== 1'b0) begin
         errors++;
         $display("FAIL auto_key: busy=%b after key press in auto mode, required 0", busy);
      end
      serve_dump(1, TIMEOUT + 1, 0);
      mode = 1'b0;
   endtask

   task automatic test_clr_abort();
      int waited;
      int seen;
      mode = 1'b0;
      for (int i = 0; i < DEPTH + 1; i++) pulse_rx(8'($urandom));
      key_press(1'b0);
      waited = 0;
      while (send_en !== 1'b1 && waited < 10) begin
         cycle();
         waited++;
      end
      checks++;
      if (send_en !== 1'b1 || tx_data !== mq[0]) begin
         errors++;
         $display("FAIL clr_first: send_en=%b tx_data=%02h required 1/%02h",
                  send_en, tx_data, mq[0]);
      end
      cycle();
      clr = 1'b1;
      cycle();
      clr = 1'b0;
      mq.delete();
      m_ovf = 1'b0;
      seen = 0;
      for (int i = 0; i < 10; i++) begin
         tx_done = (i == 2);
         if (send_en !== 1'b0) seen++;
         cycle();
      end
      tx_done = 1'b0;
      checks++;
      if (seen != 0 || busy !== 1'b0 || count !== '0 || overflow !== 1'b0) begin
         errors++;
         $display("FAIL clr_abort: sends=%0d busy=%b count=%0d overflow=%b required 0/0/0/0",
                  seen, busy, count, overflow);
      end
      rx_data = 8'h77;
      rx_done = 1'b1;
      clr     = 1'b1;
      cycle();
      rx_done = 1'b0;
      clr     = 1'b0;
      checks++;
      if (count !== '0) begin
         errors++;
         $display("FAIL clr_rx: count=%0d required 0", count);
      end
      pulse_rx(8'h5A);
      key_press(1'b0);
      serve_dump(1, 2, 0);
   endtask

   task automatic test_reset_mid_dump();
      int waited;
      mode = 1'b0;
      pulse_rx(8'h81);
      pulse_rx(8'h82);
      pulse_rx(8'h83);
      key_press(1'b0);
      waited = 0;
      while (send_en !== 1'b1 && waited < 10) begin
         cycle();
         waited++;
      end
      #2;
      rst = 1'b0;
      #1;
      checks++;
      if (tx_data !== '0 || send_en !== 1'b0 || busy !== 1'b0 || count !== '0 ||
          overflow !== 1'b0) begin
         errors++;
         $display("FAIL async_reset: tx_data=%02h send_en=%b busy=%b count=%0d overflow=%b required all 0",
                  tx_data, send_en, busy, count, overflow);
      end
      mq.delete();
      m_ovf = 1'b0;
      cycle();
      rst = 1'b1;
      cycle();
      pulse_rx(8'hC3);
      key_press(1'b0);
      serve_dump(1, 2, 0);
   endtask

   initial begin
      test_reset();
      test_basic();
      test_overflow();
      test_wrap();
      test_threshold();
      test_timeout();
      test_clr_abort();
      test_reset_mid_dump();
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
